// File: rtl/ex_div_pkg.sv
// ex_div_pkg: state encoding, handshake constants and helpers for the radix-2 restoring divider
package ex_div_pkg;
    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_t;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam int   DivIters          = 32;
    function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
        return neg ? ~v + 32'd1 : v;
    endfunction
endpackage

// File: rtl/ex_div_if.sv
// ex_div_if: execute-stage to divider request/result bundle
interface ex_div_if;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    modport master(output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i, input result_o, ready_o);
    modport slave(input signed_div_i, opdata1_i, opdata2_i, start_i, annul_i, output result_o, ready_o);
endinterface

// File: rtl/ex_div.sv
// ex_div: iterative 32-bit radix-2 restoring divider, result {remainder, quotient}
module ex_div
    import ex_div_pkg::*;
(
    input logic    clk,
    input logic    rst,
    ex_div_if.slave div
);
    div_state_t  state, state_n;
    logic [5:0]  cnt, cnt_n;
    logic [64:0] work, work_n;
    logic [31:0] divisor, divisor_n;
    logic        neg1, neg2, neg1_n, neg2_n;
    logic [63:0] result_n;
    logic        ready_n;
    logic [32:0] temp;
    logic [31:0] quot, rem;
    assign temp = {1'b0, work[63:32]} - {1'b0, divisor};
    // sign fix-up uses the operand signs captured at start, not the live inputs
    assign quot = neg_if(neg1 ^ neg2, work[31:0]);
    assign rem  = neg_if(neg1, work[64:33]);
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        work_n    = work;
        divisor_n = divisor;
        neg1_n    = neg1;
        neg2_n    = neg2;
        result_n  = div.result_o;
        ready_n   = div.ready_o;
        if (state != DivFree && div.annul_i) begin
            state_n  = DivFree;
            result_n = '0;
            ready_n  = DivResultNotReady;
        end else begin
            case (state)
                DivFree: begin
                    result_n = '0;
                    ready_n  = DivResultNotReady;
                    if (div.start_i == DivStart && !div.annul_i) begin
                        neg1_n    = div.signed_div_i & div.opdata1_i[31];
                        neg2_n    = div.signed_div_i & div.opdata2_i[31];
                        divisor_n = neg_if(neg2_n, div.opdata2_i);
                        work_n    = {32'd0, neg_if(neg1_n, div.opdata1_i), 1'b0};
                        cnt_n     = '0;
                        state_n   = (div.opdata2_i == 32'd0) ? DivByZero : DivOn;
                    end
                end
                DivByZero: begin
                    work_n  = '0;
                    state_n = DivEnd;
                end
                DivOn: begin
                    if (cnt == 6'(DivIters)) begin
                        work_n  = {rem, work[32], quot};
                        state_n = DivEnd;
                    end else begin
                        work_n = temp[32] ? work << 1 : {temp[31:0], work[31:0], 1'b1};
                        cnt_n  = cnt + 6'd1;
                    end
                end
                DivEnd: begin
                    if (div.start_i == DivStop) begin
                        state_n  = DivFree;
                        result_n = '0;
                        ready_n  = DivResultNotReady;
                    end else begin
                        result_n = {work[64:33], work[31:0]};
                        ready_n  = DivResultReady;
                    end
                end
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= DivFree;
            cnt          <= '0;
            work         <= '0;
            divisor      <= '0;
            neg1         <= 1'b0;
            neg2         <= 1'b0;
            div.result_o <= '0;
            div.ready_o  <= DivResultNotReady;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            work         <= work_n;
            divisor      <= divisor_n;
            neg1         <= neg1_n;
            neg2         <= neg2_n;
            div.result_o <= result_n;
            div.ready_o  <= ready_n;
        end
    end
endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: directed vectors against a latency/arithmetic reference model of ex_div
module tb_ex_div;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ex_div_if dif();
    ex_div dut (.clk(clk), .rst(rst), .div(dif));

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    int          phase = 0;
    int          cd = 0;
    logic [63:0] m_res = '0;
    logic [63:0] exp_result = '0;
    logic        exp_ready = 1'b0;

    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint x, y, q, r;
        if (b == 32'd0) return 64'd0;
        x = s ? longint'($signed(a)) : longint'({32'd0, a});
        y = s ? longint'($signed(b)) : longint'({32'd0, b});
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // reference: result becomes visible 34 edges after accept (2 for divide by zero), held while start stays high
    always @(posedge clk) begin
        if (rst) begin
            phase      <= 0;
            exp_ready  <= 1'b0;
            exp_result <= '0;
        end else if (phase == 0) begin
            exp_ready  <= 1'b0;
            exp_result <= '0;
            if (dif.start_i && !dif.annul_i) begin
                m_res <= ref_div(dif.signed_div_i, dif.opdata1_i, dif.opdata2_i);
                cd    <= (dif.opdata2_i == 32'd0) ? 1 : 33;
                phase <= 1;
            end
        end else if (dif.annul_i) begin
            phase      <= 0;
            exp_ready  <= 1'b0;
            exp_result <= '0;
        end else if (phase == 1) begin
            cd <= cd - 1;
            if (cd == 1) phase <= 2;
        end else if (dif.start_i) begin
            exp_ready  <= 1'b1;
            exp_result <= m_res;
        end else begin
            phase      <= 0;
            exp_ready  <= 1'b0;
            exp_result <= '0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("ready_vs_model", {63'd0, dif.ready_o}, {63'd0, exp_ready});
            check("result_vs_model", dif.result_o, exp_result);
        end
    end

    task automatic run(input string name, input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] lit, input int lat, input int chg);
        int n;
        n = 0;
        @(negedge clk);
        dif.signed_div_i = s;
        dif.opdata1_i    = a;
        dif.opdata2_i    = b;
        dif.start_i      = 1'b1;
        @(posedge clk);
        #1;
        while (!dif.ready_o && n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (n == chg) dif.opdata1_i = ~a;
        end
        check({name, "_latency"}, 64'(n), 64'(lat));
        check({name, "_result"}, dif.result_o, lit);
        @(negedge clk);
        dif.start_i = 1'b0;
        @(posedge clk);
        #1;
        check({name, "_drop_ready"}, {63'd0, dif.ready_o}, 64'd0);
        check({name, "_drop_result"}, dif.result_o, 64'd0);
    endtask

    initial begin
        dif.signed_div_i = 1'b0;
        dif.opdata1_i    = '0;
        dif.opdata2_i    = '0;
        dif.start_i      = 1'b0;
        dif.annul_i      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", {63'd0, dif.ready_o}, 64'd0);
        check("reset_result", dif.result_o, 64'd0);
        rst    = 1'b0;
        chk_en = 1'b1;

        run("u100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34, -1);
        run("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 34, -1);
        run("s_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 34, -1);
        run("s_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 34, -1);
        run("u_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 34, 5);
        run("u_div0", 1'b0, 32'd1234, 32'd0, 64'd0, 2, -1);
        run("s_div0", 1'b1, 32'hFFFFFFF0, 32'd0, 64'd0, 2, -1);

        // annul at E10, new request accepted on the following edge
        @(negedge clk);
        dif.signed_div_i = 1'b0;
        dif.opdata1_i    = 32'd200;
        dif.opdata2_i    = 32'd3;
        dif.start_i      = 1'b1;
        @(posedge clk);
        repeat (9) @(posedge clk);
        #1;
        dif.annul_i = 1'b1;
        @(posedge clk);
        #1;
        dif.annul_i = 1'b0;
        check("annul_ready", {63'd0, dif.ready_o}, 64'd0);
        run("after_annul", 1'b0, 32'd55, 32'd5, 64'h00000000_0000000B, 34, -1);

        // reset at E20 mid-divide
        @(negedge clk);
        dif.opdata1_i = 32'd1000;
        dif.opdata2_i = 32'd3;
        dif.start_i   = 1'b1;
        @(posedge clk);
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_ready", {63'd0, dif.ready_o}, 64'd0);
        check("rst_mid_result", dif.result_o, 64'd0);
        rst         = 1'b0;
        dif.start_i = 1'b0;
        run("after_rst", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 34, -1);

        @(negedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ex_div.md
Name: ex_div

Overview:
- Iterative radix-2 restoring divider used by the execute stage for DIV/DIVU.
- Execute starts it when the instruction arriving from the ID/EX register is a divide, and holds the pipeline stall request while `ready_o` is low.
- Result goes to HI (remainder) and LO (quotient) via execute and writeback.
- `annul_i` is driven by the pipeline flush, so an exception kills an in-flight divide.

Parameters:
- None. Width is fixed at 32 bits (RegBus); the iteration count of 32 is hard-coded.

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- signed_div_i  in  1  1 = DIV (signed), 0 = DIVU
- opdata1_i  in  32  dividend; sampled only when a start is accepted
- opdata2_i  in  32  divisor; sampled only when a start is accepted
- start_i  in  1  request/hold; execute keeps it high until it sees `ready_o`
- annul_i  in  1  abort the current operation (flush)
- result_o  out  64  {remainder[31:0], quotient[31:0]}; valid only while `ready_o` = 1
- ready_o  out  1  result valid

Behaviour:
- Reset: `rst` = 1 at a posedge gives state DivFree, `result_o` = 0, `ready_o` = 0, counter = 0, internal regs = 0. Reset overrides every other input.
- DivFree:
  - If `start_i` = 1 and `annul_i` = 0, capture operands.
  - If divisor = 0, go to DivByZero.
  - Otherwise go to DivOn with counter = 0.
  - In signed mode, each negative operand is replaced by its two's complement before loading.
  - Load the 65-bit working reg as {32'b0, |op1|, 1'b0}, i.e. bits [32:1] = op1, and the divisor reg as |op2|.
  - `ready_o` = 0 and `result_o` = 0 in this state.
- DivByZero: at the next edge, working reg = 0 and go to DivEnd.
- DivOn, when `annul_i` = 0 and counter < 32:
  - temp = {1'b0, work[63:32]} − {1'b0, divisor}.
  - If temp[32] = 1: work = work << 1.
  - Else: work = {temp[31:0], work[31:0], 1'b1}.
  - counter += 1.
- DivOn, when counter = 32:
  - Signed fix-up only: if sign(op1) ≠ sign(op2), negate the quotient (work[31:0]).
  - Signed fix-up only: if op1 is negative, negate the remainder (work[64:33]).
  - Go to DivEnd. The captured operand signs are used, not the current inputs.
- DivEnd:
  - `result_o` = {work[64:33], work[31:0]}, `ready_o` = 1, registered at the edge entering DivEnd + 1.
  - Hold while `start_i` = 1.
  - When `start_i` = 0 at an edge, go to DivFree, `ready_o` = 0, `result_o` = 0.
- Annul: `annul_i` = 1 at any edge in DivByZero, DivOn or DivEnd gives DivFree, `ready_o` = 0, `result_o` = 0. A start with annul in DivFree is ignored.
- Latency, with edge E0 accepting the start:
  - Normal: E1..E32 iterate, E33 fix-up, `ready_o` = 1 after E34.
  - Divide by zero: `ready_o` = 1 after E2, result = 0.
- Operand changes after E0 have no effect.
- `start_i` held high across back-to-back divides: a new start is accepted only after returning to DivFree, which requires one cycle with `start_i` = 0. Execute deasserts `start_i` for one cycle after consuming the result.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (wraps; no trap).

Decomposition:
- Shared constants in defines.v:
  - DivFree 2'b00, DivByZero 2'b01, DivOn 2'b10, DivEnd 2'b11
  - DivResultReady 1'b1, DivResultNotReady 1'b0
  - DivStart 1'b1, DivStop 1'b0
- Single module; no sub-module is natural. The one-step subtract is a local combinational expression.

Test Plan:
- Unsigned 100 / 7, `start_i` held → `ready_o` rises after edge E34; `result_o` = 0x00000002_0000000E. Drop `start_i` → next edge `ready_o` = 0, `result_o` = 0.
- Signed −7 / 2 (0xFFFFFFF9, 0x00000002) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 0x80000000 / 0xFFFFFFFF → 0x00000000_80000000.
- Unsigned 0xFFFFFFFF / 0x00000001 → 0x00000000_FFFFFFFF at E34. Change `opdata1_i` at E5 → result unchanged.
- Divisor 0, both modes → `ready_o` = 1 after E2; `result_o` = 0.
- `annul_i` pulsed at E10 → state DivFree, `ready_o` stays 0. New start 55 / 5 accepted next cycle → 0x00000000_0000000B after its E34.
- `rst` asserted at E20 mid-divide → all outputs 0 the following cycle. A fresh start after reset completes correctly (9 / 3 → 0x00000000_00000003).
